// File: rtl/regsched_pkg.sv
// Shared types and constants for the register-file port scheduler.
package regsched_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned IDX_W_DEF  = 5;

  // Encoding of the round-robin last-grant register
  localparam logic GNT_RD = 1'b0;
  localparam logic GNT_WR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRdRs,
    StRdRt,
    StRdLast,
    StResp
  } state_e;

endpackage

// File: rtl/regfile_port_scheduler_if.sv
// Request/response and register-file port bundle for regfile_port_scheduler.
interface regfile_port_scheduler_if
  import regsched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [IDX_W-1:0]  rd_rs;
  logic [IDX_W-1:0]  rd_rt;
  logic              rd_two;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_flag1;
  logic              rd_flag2;
  logic              rd_hazard;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [IDX_W-1:0]  wr_index;
  logic [DATA_W-1:0] wr_data;
  logic [IDX_W-1:0]  rf_index;
  logic [DATA_W-1:0] rf_value_in;
  logic              rf_read_en;
  logic              rf_write_en;
  logic [DATA_W-1:0] rf_value_out;
  logic              rf_flag_out;

  // Requesters plus the register file itself
  modport master (
    output rd_req_valid, rd_rs, rd_rt, rd_two, wr_req_valid, wr_index, wr_data,
           rf_value_out, rf_flag_out,
    input  rd_req_ready, rd_resp_valid, rd_data1, rd_data2, rd_flag1, rd_flag2, rd_hazard,
           wr_req_ready, rf_index, rf_value_in, rf_read_en, rf_write_en
  );

  modport slave (
    input  rd_req_valid, rd_rs, rd_rt, rd_two, wr_req_valid, wr_index, wr_data,
           rf_value_out, rf_flag_out,
    output rd_req_ready, rd_resp_valid, rd_data1, rd_data2, rd_flag1, rd_flag2, rd_hazard,
           wr_req_ready, rf_index, rf_value_in, rf_read_en, rf_write_en
  );
endinterface

// File: rtl/regsched_rr_arb.sv
// Two-way round-robin arbiter (read vs write) with a last-grant register.
module regsched_rr_arb
  import regsched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_rd,
  input  logic i_req_wr,
  output logic o_gnt_rd,
  output logic o_gnt_wr
);

  logic r_last;
  logic w_last_d;
  logic w_gnt_rd;
  logic w_gnt_wr;

  always_comb begin
    // On contention, favour whoever did not win last time
    w_gnt_rd = i_en & i_req_rd & (~i_req_wr | (r_last == GNT_WR));
    w_gnt_wr = i_en & i_req_wr & ~w_gnt_rd;
    w_last_d = r_last;
    if (w_gnt_rd) begin
      w_last_d = GNT_RD;
    end else if (w_gnt_wr) begin
      w_last_d = GNT_WR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= GNT_WR;
    end else begin
      r_last <= w_last_d;
    end
  end

  assign o_gnt_rd = w_gnt_rd;
  assign o_gnt_wr = w_gnt_wr;

endmodule

// File: rtl/regfile_port_scheduler.sv
// Shares one register-file port between a decode reader and a writeback writer.
// Optional REGSCHED_ZERO_REG_EN: index 0 reads skip the port and return 0 / flag 1.
module regfile_port_scheduler
  import regsched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  regfile_port_scheduler_if.slave bus
);

  state_e            r_state, w_state_d;
  logic [IDX_W-1:0]  r_rs, w_rs_d, r_rt, w_rt_d;
  logic              r_two, w_two_d;
  logic [DATA_W-1:0] r_data1, w_data1_d, r_data2, w_data2_d;
  logic              r_flag1, w_flag1_d, r_flag2, w_flag2_d, r_hazard, w_hazard_d;

  logic              w_idle, w_gnt_rd, w_gnt_wr;
  logic              w_rs_zero, w_rt_zero;
  logic [DATA_W-1:0] w_ret_rs, w_ret_rt;
  logic              w_flg_rs, w_flg_rt;
  logic [IDX_W-1:0]  w_rf_index;
  logic [DATA_W-1:0] w_rf_value_in;
  logic              w_rf_read_en, w_rf_write_en;

  // Gating with rst_n keeps every output quiet while reset is held
  assign w_idle = rst_n && (r_state == StIdle);

  regsched_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_idle),
    .i_req_rd(bus.rd_req_valid),
    .i_req_wr(bus.wr_req_valid),
    .o_gnt_rd(w_gnt_rd),
    .o_gnt_wr(w_gnt_wr)
  );

`ifdef REGSCHED_ZERO_REG_EN
  assign w_rs_zero = (r_rs == '0);
  assign w_rt_zero = (r_rt == '0);
`else
  assign w_rs_zero = 1'b0;
  assign w_rt_zero = 1'b0;
`endif

  assign w_ret_rs = w_rs_zero ? '0 : bus.rf_value_out;
  assign w_flg_rs = w_rs_zero | bus.rf_flag_out;
  assign w_ret_rt = w_rt_zero ? '0 : bus.rf_value_out;
  assign w_flg_rt = w_rt_zero | bus.rf_flag_out;

  always_comb begin
    w_state_d     = r_state;
    w_rs_d        = r_rs;
    w_rt_d        = r_rt;
    w_two_d       = r_two;
    w_data1_d     = r_data1;
    w_data2_d     = r_data2;
    w_flag1_d     = r_flag1;
    w_flag2_d     = r_flag2;
    w_hazard_d    = r_hazard;
    w_rf_index    = '0;
    w_rf_value_in = '0;
    w_rf_read_en  = 1'b0;
    w_rf_write_en = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_gnt_wr) begin
          w_rf_write_en = 1'b1;
          w_rf_index    = bus.wr_index;
          w_rf_value_in = bus.wr_data;
        end else if (w_gnt_rd) begin
          w_rs_d    = bus.rd_rs;
          w_rt_d    = bus.rd_rt;
          w_two_d   = bus.rd_two;
          w_state_d = StRdRs;
        end
      end
      StRdRs: begin
        if (!w_rs_zero) begin
          w_rf_read_en = 1'b1;
          w_rf_index   = r_rs;
        end
        w_state_d = r_two ? StRdRt : StRdLast;
      end
      StRdRt: begin
        if (!w_rt_zero) begin
          w_rf_read_en = 1'b1;
          w_rf_index   = r_rt;
        end
        w_data1_d = w_ret_rs;
        w_flag1_d = w_flg_rs;
        w_state_d = StRdLast;
      end
      StRdLast: begin
        if (r_two) begin
          w_data2_d = w_ret_rt;
          w_flag2_d = w_flg_rt;
        end else begin
          w_data1_d = w_ret_rs;
          w_flag1_d = w_flg_rs;
          w_data2_d = '0;
          w_flag2_d = 1'b1;
        end
        w_hazard_d = ~w_flag1_d | (r_two & ~w_flag2_d);
        w_state_d  = StResp;
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_rs     <= '0;
      r_rt     <= '0;
      r_two    <= 1'b0;
      r_data1  <= '0;
      r_data2  <= '0;
      r_flag1  <= 1'b0;
      r_flag2  <= 1'b0;
      r_hazard <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_rs     <= w_rs_d;
      r_rt     <= w_rt_d;
      r_two    <= w_two_d;
      r_data1  <= w_data1_d;
      r_data2  <= w_data2_d;
      r_flag1  <= w_flag1_d;
      r_flag2  <= w_flag2_d;
      r_hazard <= w_hazard_d;
    end
  end

  assign bus.rd_req_ready  = w_gnt_rd;
  assign bus.wr_req_ready  = w_gnt_wr;
  assign bus.rd_resp_valid = (r_state == StResp);
  assign bus.rd_data1      = r_data1;
  assign bus.rd_data2      = r_data2;
  assign bus.rd_flag1      = r_flag1;
  assign bus.rd_flag2      = r_flag2;
  assign bus.rd_hazard     = r_hazard;
  assign bus.rf_index      = w_rf_index;
  assign bus.rf_value_in   = w_rf_value_in;
  assign bus.rf_read_en    = w_rf_read_en;
  assign bus.rf_write_en   = w_rf_write_en;

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Directed bench for regfile_port_scheduler with a behavioural register-file responder.
module tb_regfile_port_scheduler;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_port_scheduler_if #(.DATA_W(DW), .IDX_W(IW)) bus_if ();

  regfile_port_scheduler #(.DATA_W(DW), .IDX_W(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Register file: values come from writes through the DUT, flags are fixed here
  logic [DW-1:0] mem_val [32];
  logic          mem_flg [32];

  always @(posedge clk) begin
    if (bus_if.rf_write_en) mem_val[bus_if.rf_index] <= bus_if.rf_value_in;
    if (bus_if.rf_read_en) begin
      bus_if.rf_value_out <= mem_val[bus_if.rf_index];
      bus_if.rf_flag_out  <= mem_flg[bus_if.rf_index];
    end else begin
      bus_if.rf_value_out <= 32'hDEAD_BEEF;
      bus_if.rf_flag_out  <= 1'b0;
    end
  end

  int both_en_cnt    = 0;
  int idle_drive_cnt = 0;
  always @(negedge clk) begin
    if (bus_if.rf_read_en && bus_if.rf_write_en) both_en_cnt++;
    if (!bus_if.rf_read_en && !bus_if.rf_write_en &&
        (bus_if.rf_index != 0 || bus_if.rf_value_in != 0)) idle_drive_cnt++;
  end

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wvec_t;

  typedef struct {
    logic [IW-1:0] rs;
    logic [IW-1:0] rt;
    logic          two;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          f1;
    logic          f2;
    logic          hz;
    int            lat;
    int            nrd;
  } rvec_t;

  task automatic do_write(input wvec_t v);
    @(negedge clk);
    bus_if.wr_req_valid = 1'b1;
    bus_if.wr_index     = v.idx;
    bus_if.wr_data      = v.data;
    #1;
    check("wr_ready", bus_if.wr_req_ready, 1);
    check("wr_en", bus_if.rf_write_en, 1);
    check("wr_rf_index", bus_if.rf_index, v.idx);
    check("wr_rf_value", bus_if.rf_value_in, v.data);
    check("wr_no_read_en", bus_if.rf_read_en, 0);
    @(posedge clk);
    #1;
    bus_if.wr_req_valid = 1'b0;
  endtask

  task automatic do_read(input rvec_t v);
    int cyc;
    int nrd;
    bit got;
    @(negedge clk);
    bus_if.rd_req_valid = 1'b1;
    bus_if.rd_rs        = v.rs;
    bus_if.rd_rt        = v.rt;
    bus_if.rd_two       = v.two;
    #1;
    check("rd_ready", bus_if.rd_req_ready, 1);
    @(posedge clk);
    #1;
    bus_if.rd_req_valid = 1'b0;
    cyc = 0;
    nrd = 0;
    got = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus_if.rf_read_en) nrd++;
      if (bus_if.rd_resp_valid) got = 1;
    end
    check("rd_latency", cyc, v.lat);
    check("rd_data1", bus_if.rd_data1, v.d1);
    check("rd_data2", bus_if.rd_data2, v.d2);
    check("rd_flag1", bus_if.rd_flag1, v.f1);
    check("rd_flag2", bus_if.rd_flag2, v.f2);
    check("rd_hazard", bus_if.rd_hazard, v.hz);
    check("rd_port_reads", nrd, v.nrd);
    @(negedge clk);
    check("rd_resp_one_cycle", bus_if.rd_resp_valid, 0);
    check("rd_data1_hold", bus_if.rd_data1, v.d1);
  endtask

  wvec_t wtab [7];
  rvec_t rtab [5];

  initial begin
    int  busy_bad;
    int  cyc;
    bit  got;
    int  resp_seen;

    wtab[0] = '{idx: 5'd1, data: 32'h0000_000A};
    wtab[1] = '{idx: 5'd2, data: 32'h0000_000B};
    wtab[2] = '{idx: 5'd5, data: 32'h0000_0077};
    wtab[3] = '{idx: 5'd7, data: 32'h0000_0055};
    wtab[4] = '{idx: 5'd4, data: 32'h0000_0044};
    wtab[5] = '{idx: 5'd0, data: 32'h0000_0099};
    wtab[6] = '{idx: 5'd3, data: 32'h0000_1234};

    rtab[0] = '{rs: 5'd1, rt: 5'd2, two: 1'b1, d1: 32'hA, d2: 32'hB, f1: 1'b1, f2: 1'b0,
                hz: 1'b1, lat: 4, nrd: 2};
    rtab[1] = '{rs: 5'd5, rt: 5'd0, two: 1'b0, d1: 32'h77, d2: 32'h0, f1: 1'b1, f2: 1'b1,
                hz: 1'b0, lat: 3, nrd: 1};
    rtab[2] = '{rs: 5'd7, rt: 5'd0, two: 1'b0, d1: 32'h55, d2: 32'h0, f1: 1'b0, f2: 1'b1,
                hz: 1'b1, lat: 3, nrd: 1};
`ifdef REGSCHED_ZERO_REG_EN
    rtab[3] = '{rs: 5'd0, rt: 5'd4, two: 1'b1, d1: 32'h0, d2: 32'h44, f1: 1'b1, f2: 1'b1,
                hz: 1'b0, lat: 4, nrd: 1};
`else
    rtab[3] = '{rs: 5'd0, rt: 5'd4, two: 1'b1, d1: 32'h99, d2: 32'h44, f1: 1'b1, f2: 1'b1,
                hz: 1'b0, lat: 4, nrd: 2};
`endif
    rtab[4] = '{rs: 5'd4, rt: 5'd7, two: 1'b1, d1: 32'h44, d2: 32'h55, f1: 1'b1, f2: 1'b0,
                hz: 1'b1, lat: 4, nrd: 2};

    for (int i = 0; i < 32; i++) mem_flg[i] = 1'b1;
    mem_flg[2] = 1'b0;
    mem_flg[7] = 1'b0;

    // Both requesters active while reset is held: everything must stay at 0
    bus_if.rd_req_valid = 1'b1;
    bus_if.rd_rs        = 5'd1;
    bus_if.rd_rt        = 5'd2;
    bus_if.rd_two       = 1'b1;
    bus_if.wr_req_valid = 1'b1;
    bus_if.wr_index     = 5'd6;
    bus_if.wr_data      = 32'h66;
    #12;
    check("rst_rd_ready", bus_if.rd_req_ready, 0);
    check("rst_wr_ready", bus_if.wr_req_ready, 0);
    check("rst_write_en", bus_if.rf_write_en, 0);
    check("rst_read_en", bus_if.rf_read_en, 0);
    check("rst_rf_index", bus_if.rf_index, 0);
    check("rst_rf_value", bus_if.rf_value_in, 0);
    check("rst_resp", bus_if.rd_resp_valid, 0);
    check("rst_data1", bus_if.rd_data1, 0);
    check("rst_flag2", bus_if.rd_flag2, 0);
    check("rst_hazard", bus_if.rd_hazard, 0);

    // First contention after reset goes to the reader
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arb_first_rd_ready", bus_if.rd_req_ready, 1);
    check("arb_first_wr_ready", bus_if.wr_req_ready, 0);
    check("arb_first_write_en", bus_if.rf_write_en, 0);
    @(posedge clk);
    #1;
    busy_bad = 0;
    got      = 0;
    cyc      = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus_if.rd_req_ready || bus_if.wr_req_ready) busy_bad++;
      if (bus_if.rd_resp_valid) got = 1;
    end
    check("arb_busy_no_ready", busy_bad, 0);
    check("arb_rd_latency", cyc, 4);
    @(negedge clk);
    check("arb_then_wr_ready", bus_if.wr_req_ready, 1);
    check("arb_then_rd_ready", bus_if.rd_req_ready, 0);
    check("arb_then_write_en", bus_if.rf_write_en, 1);
    check("arb_then_rf_index", bus_if.rf_index, 6);
    @(negedge clk);
    check("arb_rr_rd_ready", bus_if.rd_req_ready, 1);
    check("arb_rr_wr_ready", bus_if.wr_req_ready, 0);
    bus_if.wr_req_valid = 1'b0;
    @(posedge clk);
    #1;
    bus_if.rd_req_valid = 1'b0;
    got = 0;
    cyc = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus_if.rd_resp_valid) got = 1;
    end
    check("arb_drain_resp", got, 1);

    for (int i = 0; i < 7; i++) do_write(wtab[i]);
    for (int i = 0; i < 5; i++) do_read(rtab[i]);

    // Reset in the middle of a two-operand read
    @(negedge clk);
    bus_if.rd_req_valid = 1'b1;
    bus_if.rd_rs        = 5'd1;
    bus_if.rd_rt        = 5'd2;
    bus_if.rd_two       = 1'b1;
    @(posedge clk);
    #1;
    bus_if.rd_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rd_rt_read_en", bus_if.rf_read_en, 1);
    check("mid_rd_rt_index", bus_if.rf_index, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_read_en", bus_if.rf_read_en, 0);
    check("mid_rst_rf_index", bus_if.rf_index, 0);
    check("mid_rst_data1", bus_if.rd_data1, 0);
    check("mid_rst_data2", bus_if.rd_data2, 0);
    check("mid_rst_flag1", bus_if.rd_flag1, 0);
    check("mid_rst_hazard", bus_if.rd_hazard, 0);
    resp_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_if.rd_resp_valid) resp_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_if.rd_resp_valid) resp_seen++;
    end
    check("mid_rst_no_resp", resp_seen, 0);
    do_read(rtab[1]);

    check("never_both_enables", both_en_cnt, 0);
    check("idle_port_zero", idle_drive_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
